// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: decodes the ID instruction into an ALU code, forwards and
// selects the two ALU operands, detects load-use hazards and registers everything for EX.
module id_ex_operand_stage #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [6:0]            id_opcode,
  input  logic [2:0]            id_funct3,
  input  logic                  id_funct7_5,
  input  logic [4:0]            id_rs1,
  input  logic [4:0]            id_rs2,
  input  logic [4:0]            id_rd,
  input  logic [DATA_WIDTH-1:0] id_rs1_data,
  input  logic [DATA_WIDTH-1:0] id_rs2_data,
  input  logic [DATA_WIDTH-1:0] id_imm,
  input  logic [DATA_WIDTH-1:0] id_pc,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  exmem_reg_write,
  input  logic [4:0]            exmem_rd,
  input  logic [DATA_WIDTH-1:0] exmem_result,
  input  logic                  memwb_reg_write,
  input  logic [4:0]            memwb_rd,
  input  logic [DATA_WIDTH-1:0] memwb_data,
  output logic                  hazard_stall,
  output logic                  ex_valid,
  output logic [3:0]            ex_alu_op,
  output logic [DATA_WIDTH-1:0] ex_alu_in_1,
  output logic [DATA_WIDTH-1:0] ex_alu_in_2,
  output logic [4:0]            ex_rd,
  output logic                  ex_is_load,
  output logic                  ex_illegal
);

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_SLL = 4'd2;
  localparam logic [3:0] ALU_XOR = 4'd3;
  localparam logic [3:0] ALU_SRL = 4'd4;
  localparam logic [3:0] ALU_OR  = 4'd5;
  localparam logic [3:0] ALU_AND = 4'd6;
  localparam logic [3:0] ALU_BEQ = 4'd7;
  localparam logic [3:0] ALU_BNE = 4'd8;
  localparam logic [3:0] ALU_BLT = 4'd9;
  localparam logic [3:0] ALU_BGE = 4'd10;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // Returns {illegal, alu_op}; funct7[5] selects SUB on R-type and marks SRA/SRAI illegal.
  function automatic logic [4:0] map_alu(input logic [2:0] f3, input logic f7_5,
                                         input logic is_r);
    logic [4:0] res;
    case (f3)
      3'b000:  res = {1'b0, (is_r && f7_5) ? ALU_SUB : ALU_ADD};
      3'b001:  res = {1'b0, ALU_SLL};
      3'b100:  res = {1'b0, ALU_XOR};
      3'b101:  res = {f7_5, ALU_SRL};
      3'b110:  res = {1'b0, ALU_OR};
      3'b111:  res = {1'b0, ALU_AND};
      default: res = {1'b1, ALU_ADD};
    endcase
    return res;
  endfunction

  function automatic logic [4:0] map_branch(input logic [2:0] f3);
    logic [4:0] res;
    case (f3)
      3'b000:  res = {1'b0, ALU_BEQ};
      3'b001:  res = {1'b0, ALU_BNE};
      3'b100:  res = {1'b0, ALU_BLT};
      3'b101:  res = {1'b0, ALU_BGE};
      default: res = {1'b1, ALU_ADD};
    endcase
    return res;
  endfunction

  logic [DATA_WIDTH-1:0] w_fwd1;
  logic [DATA_WIDTH-1:0] w_fwd2;
  logic [DATA_WIDTH-1:0] w_shamt_imm;
  logic [DATA_WIDTH-1:0] w_in1;
  logic [DATA_WIDTH-1:0] w_in2;
  logic [3:0]            w_alu_op;
  logic                  w_use_rs1;
  logic                  w_use_rs2;
  logic                  w_writes_rd;
  logic                  w_is_load;
  logic                  w_illegal;
  logic                  w_hazard;
  logic                  w_accept;

  logic                  r_ex_valid_p1;
  logic [3:0]            r_ex_alu_op_p1;
  logic [DATA_WIDTH-1:0] r_ex_in1_p1;
  logic [DATA_WIDTH-1:0] r_ex_in2_p1;
  logic [4:0]            r_ex_rd_p1;
  logic                  r_ex_is_load_p1;
  logic                  r_ex_illegal_p1;

  // ID decode, forwarding and operand select
  assign w_fwd1 = (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == id_rs1) ? exmem_result :
                  (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == id_rs1) ? memwb_data :
                  id_rs1_data;
  assign w_fwd2 = (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == id_rs2) ? exmem_result :
                  (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == id_rs2) ? memwb_data :
                  id_rs2_data;
  assign w_shamt_imm = {{(DATA_WIDTH-5){1'b0}}, id_imm[4:0]};

  always_comb begin
    w_alu_op    = ALU_ADD;
    w_in1       = '0;
    w_in2       = '0;
    w_use_rs1   = 1'b0;
    w_use_rs2   = 1'b0;
    w_writes_rd = 1'b0;
    w_is_load   = 1'b0;
    w_illegal   = 1'b0;
    case (id_opcode)
      OPC_R: begin
        w_use_rs1   = 1'b1;
        w_use_rs2   = 1'b1;
        w_writes_rd = 1'b1;
        {w_illegal, w_alu_op} = map_alu(id_funct3, id_funct7_5, 1'b1);
        w_in1 = w_fwd1;
        w_in2 = w_fwd2;
      end
      OPC_I: begin
        w_use_rs1   = 1'b1;
        w_writes_rd = 1'b1;
        {w_illegal, w_alu_op} = map_alu(id_funct3, id_funct7_5, 1'b0);
        w_in1 = w_fwd1;
        w_in2 = (id_funct3 == 3'b001 || id_funct3 == 3'b101) ? w_shamt_imm : id_imm;
      end
      OPC_LOAD: begin
        w_use_rs1   = 1'b1;
        w_writes_rd = 1'b1;
        w_is_load   = 1'b1;
        w_in1 = w_fwd1;
        w_in2 = id_imm;
      end
      OPC_STORE: begin
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
        w_in1 = w_fwd1;
        w_in2 = id_imm;
      end
      OPC_JALR: begin
        w_use_rs1   = 1'b1;
        w_writes_rd = 1'b1;
        w_in1 = w_fwd1;
        w_in2 = id_imm;
      end
      OPC_LUI: begin
        w_writes_rd = 1'b1;
        w_in2 = id_imm;
      end
      OPC_AUIPC, OPC_JAL: begin
        w_writes_rd = 1'b1;
        w_in1 = id_pc;
        w_in2 = id_imm;
      end
      OPC_BRANCH: begin
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
        {w_illegal, w_alu_op} = map_branch(id_funct3);
        w_in1 = w_fwd1;
        w_in2 = w_fwd2;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // A load in EX cannot forward its data yet, so a dependent ID instruction waits one cycle.
  assign w_hazard = id_valid && r_ex_valid_p1 && r_ex_is_load_p1 && (r_ex_rd_p1 != 5'd0) &&
                    ((w_use_rs1 && r_ex_rd_p1 == id_rs1) || (w_use_rs2 && r_ex_rd_p1 == id_rs2));
  assign w_accept = id_valid && !w_illegal && !w_hazard;

  // ID/EX register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex_valid_p1   <= 1'b0;
      r_ex_alu_op_p1  <= ALU_ADD;
      r_ex_in1_p1     <= '0;
      r_ex_in2_p1     <= '0;
      r_ex_rd_p1      <= 5'd0;
      r_ex_is_load_p1 <= 1'b0;
      r_ex_illegal_p1 <= 1'b0;
    end else if (flush) begin
      r_ex_valid_p1   <= 1'b0;
      r_ex_rd_p1      <= 5'd0;
      r_ex_is_load_p1 <= 1'b0;
      r_ex_illegal_p1 <= 1'b0;
    end else if (stall) begin
      // The illegal flag is an event, not stage content, so it never stretches.
      r_ex_illegal_p1 <= 1'b0;
    end else begin
      r_ex_valid_p1   <= w_accept;
      r_ex_alu_op_p1  <= w_alu_op;
      r_ex_in1_p1     <= w_in1;
      r_ex_in2_p1     <= w_in2;
      r_ex_rd_p1      <= (w_accept && w_writes_rd) ? id_rd : 5'd0;
      r_ex_is_load_p1 <= w_accept && w_is_load;
      r_ex_illegal_p1 <= id_valid && w_illegal && !w_hazard;
    end
  end

  assign hazard_stall = w_hazard;
  assign ex_valid     = r_ex_valid_p1;
  assign ex_alu_op    = r_ex_alu_op_p1;
  assign ex_alu_in_1  = r_ex_in1_p1;
  assign ex_alu_in_2  = r_ex_in2_p1;
  assign ex_rd        = r_ex_rd_p1;
  assign ex_is_load   = r_ex_is_load_p1;
  assign ex_illegal   = r_ex_illegal_p1;

endmodule
